// File: rtl/button_pulse_gen.sv
// button_pulse_gen: conditions raw up/down push-buttons into clean single-cycle
// increment/decrement pulses with optional auto-repeat. Each button passes through
// a 2-flop synchronizer and a debouncer; a shared FSM turns the debounced levels
// into registered pulses, each followed by at least one low cycle.
module button_pulse_gen #(
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 5000000,
    parameter int unsigned REPEAT_PERIOD   = 2000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_up_i,
    input  logic btn_dn_i,
    input  logic repeat_en_i,
    output logic incr_o,
    output logic decr_o,
    output logic up_db_o,
    output logic dn_db_o
);

    // Terminal counts, precomputed at timer width.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HOLD_UP = 3'd1;
    localparam logic [2:0] S_HOLD_DN = 3'd2;
    localparam logic [2:0] S_REP_UP  = 3'd3;
    localparam logic [2:0] S_REP_DN  = 3'd4;
    localparam logic [2:0] S_BLOCKED = 3'd5;

    logic             r_up_meta;
    logic             r_up_sync;
    logic             r_dn_meta;
    logic             r_dn_sync;
    logic [CNT_W-1:0] r_up_cnt;
    logic [CNT_W-1:0] r_dn_cnt;
    logic             r_up_stable;
    logic             r_dn_stable;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_incr;
    logic             r_decr;

    logic [2:0]       w_state_d;
    logic [CNT_W-1:0] w_timer_d;
    logic             w_incr_d;
    logic             w_decr_d;

    // Two-flop synchronizers for both raw buttons.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_up_meta <= 1'b0;
            r_up_sync <= 1'b0;
            r_dn_meta <= 1'b0;
            r_dn_sync <= 1'b0;
        end else begin
            r_up_meta <= btn_up_i;
            r_up_sync <= r_up_meta;
            r_dn_meta <= btn_dn_i;
            r_dn_sync <= r_dn_meta;
        end
    end

    // Up debouncer: stable level flips only after DEBOUNCE_CYCLES consecutive differences.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_up_cnt    <= '0;
            r_up_stable <= 1'b0;
        end else if (r_up_sync == r_up_stable) begin
            r_up_cnt <= '0;
        end else if (r_up_cnt == DB_LAST) begin
            r_up_stable <= r_up_sync;
            r_up_cnt    <= '0;
        end else begin
            r_up_cnt <= r_up_cnt + CNT_W'(1);
        end
    end

    // Down debouncer, identical to the up path.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_dn_cnt    <= '0;
            r_dn_stable <= 1'b0;
        end else if (r_dn_sync == r_dn_stable) begin
            r_dn_cnt <= '0;
        end else if (r_dn_cnt == DB_LAST) begin
            r_dn_stable <= r_dn_sync;
            r_dn_cnt    <= '0;
        end else begin
            r_dn_cnt <= r_dn_cnt + CNT_W'(1);
        end
    end

    // Press / auto-repeat FSM next-state and pulse decode.
    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_incr_d  = 1'b0;
        w_decr_d  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_d = '0;
                if (r_up_stable && r_dn_stable) begin
                    w_state_d = S_BLOCKED;
                end else if (r_up_stable) begin
                    w_incr_d  = 1'b1;
                    w_state_d = S_HOLD_UP;
                end else if (r_dn_stable) begin
                    w_decr_d  = 1'b1;
                    w_state_d = S_HOLD_DN;
                end
            end
            S_HOLD_UP, S_REP_UP: begin
                // A second button always wins over release so a conflict can't leak a pulse.
                if (r_dn_stable) begin
                    w_state_d = S_BLOCKED;
                    w_timer_d = '0;
                end else if (!r_up_stable) begin
                    w_state_d = S_IDLE;
                    w_timer_d = '0;
                end else if (!repeat_en_i) begin
                    w_timer_d = '0;
                end else if ((r_state == S_HOLD_UP && r_timer == DLY_LAST) ||
                             (r_state == S_REP_UP && r_timer == PER_LAST)) begin
                    w_incr_d  = 1'b1;
                    w_timer_d = '0;
                    w_state_d = S_REP_UP;
                end else begin
                    w_timer_d = r_timer + CNT_W'(1);
                end
            end
            S_HOLD_DN, S_REP_DN: begin
                if (r_up_stable) begin
                    w_state_d = S_BLOCKED;
                    w_timer_d = '0;
                end else if (!r_dn_stable) begin
                    w_state_d = S_IDLE;
                    w_timer_d = '0;
                end else if (!repeat_en_i) begin
                    w_timer_d = '0;
                end else if ((r_state == S_HOLD_DN && r_timer == DLY_LAST) ||
                             (r_state == S_REP_DN && r_timer == PER_LAST)) begin
                    w_decr_d  = 1'b1;
                    w_timer_d = '0;
                    w_state_d = S_REP_DN;
                end else begin
                    w_timer_d = r_timer + CNT_W'(1);
                end
            end
            S_BLOCKED: begin
                w_timer_d = '0;
                if (!r_up_stable && !r_dn_stable) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_timer_d = '0;
            end
        endcase
    end

    // FSM state, repeat timer and registered pulse outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_incr  <= 1'b0;
            r_decr  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_incr  <= w_incr_d;
            r_decr  <= w_decr_d;
        end
    end

    assign incr_o  = r_incr;
    assign decr_o  = r_decr;
    assign up_db_o = r_up_stable;
    assign dn_db_o = r_dn_stable;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with small timing parameters
// (debounce 4, repeat delay 20, repeat period 8).
module tb_button_pulse_gen;

    localparam int unsigned DB  = 4;
    localparam int unsigned DLY = 20;
    localparam int unsigned PER = 8;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic rep_en = 1'b0;
    logic incr;
    logic decr;
    logic up_db;
    logic dn_db;

    button_pulse_gen #(
        .CNT_W          (8),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .btn_up_i   (btn_up),
        .btn_dn_i   (btn_dn),
        .repeat_en_i(rep_en),
        .incr_o     (incr),
        .decr_o     (decr),
        .up_db_o    (up_db),
        .dn_db_o    (dn_db)
    );

    always #5 clk = ~clk;

    // Edge count: value N seen after edge N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder and invariant monitors, sampled mid-cycle.
    int   incr_times[$];
    int   decr_times[$];
    int   both_hi = 0;
    int   wide    = 0;
    int   up_rise = 0;
    logic p_incr  = 1'b0;
    logic p_decr  = 1'b0;
    logic p_updb  = 1'b0;
    always @(negedge clk) begin
        if (incr) incr_times.push_back(cyc);
        if (decr) decr_times.push_back(cyc);
        if (incr && decr) both_hi <= both_hi + 1;
        if ((incr && p_incr) || (decr && p_decr)) wide <= wide + 1;
        if (up_db && !p_updb) up_rise <= up_rise + 1;
        p_incr <= incr;
        p_decr <= decr;
        p_updb <= up_db;
    end

    // Downstream 0-9 counter with rising-edge detection.
    int   digit = 0;
    logic c_pi  = 1'b0;
    logic c_pd  = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            digit <= 0;
            c_pi  <= 1'b0;
            c_pd  <= 1'b0;
        end else begin
            c_pi <= incr;
            c_pd <= decr;
            if (incr && !c_pi && digit < 9) digit <= digit + 1;
            else if (decr && !c_pd && digit > 0) digit <= digit - 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        for (int g = 0; g < 2000 && cyc < t; g++) tick(1);
    endtask

    task automatic clear_log();
        incr_times.delete();
        decr_times.delete();
    endtask

    int rel;
    int t0;
    int k_rise;
    int bw[15] = '{1, 2, 3, 1, 3, 2, 2, 1, 3, 1, 2, 3, 1, 2, 3};
    int rw[6]  = '{2, 1, 3, 2, 1, 3};
    int rep_off[6] = '{0, 20, 28, 36, 44, 52};

    initial begin
        // Reset with up held: outputs stay low, then a full debounce from scratch.
        rst_n  = 1'b0;
        btn_up = 1'b1;
        tick(3);
        check("rst_incr", int'(incr), 0);
        check("rst_decr", int'(decr), 0);
        check("rst_up_db", int'(up_db), 0);
        check("rst_dn_db", int'(dn_db), 0);
        rel   = cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 30 && incr_times.size() == 0; i++) tick(1);
        check("rst_latency", (incr_times.size() > 0) ? incr_times[0] - rel : -1, 7);
        tick(30);
        check("rst_single_pulse", incr_times.size(), 1);
        btn_up = 1'b0;
        tick(15);
        clear_log();

        // Bouncy press then clean hold, repeat disabled.
        k_rise = up_rise;
        for (int i = 0; i < 15; i++) begin
            btn_up = (i % 2 == 0);
            tick(bw[i]);
        end
        btn_up = 1'b1;
        tick(50);
        check("bounce_pulses", incr_times.size(), 1);
        check("bounce_db_rises", up_rise - k_rise, 1);
        check("bounce_db_high", int'(up_db), 1);
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 1);
            tick(rw[i]);
        end
        btn_up = 1'b0;
        tick(20);
        check("release_no_pulse", incr_times.size(), 1);
        check("release_db_low", int'(up_db), 0);
        clear_log();

        // Auto-repeat on down.
        rep_en = 1'b1;
        btn_dn = 1'b1;
        for (int i = 0; i < 30 && decr_times.size() == 0; i++) tick(1);
        check("rep_first_seen", int'(decr_times.size() > 0), 1);
        t0 = (decr_times.size() > 0) ? decr_times[0] : cyc;
        wait_until(t0 + 50);
        btn_dn = 1'b0;
        tick(30);
        check("rep_count", decr_times.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("rep_offset%0d", k),
                  (k < decr_times.size()) ? decr_times[k] - t0 : -1, rep_off[k]);
        check("rep_no_incr", incr_times.size(), 0);
        clear_log();

        // Conflict: down pressed while up held, up released first.
        btn_up = 1'b1;
        for (int i = 0; i < 30 && incr_times.size() == 0; i++) tick(1);
        check("conf_first_seen", int'(incr_times.size() > 0), 1);
        t0 = (incr_times.size() > 0) ? incr_times[0] : cyc;
        wait_until(t0 + 10);
        btn_dn = 1'b1;
        wait_until(t0 + 30);
        btn_up = 1'b0;
        wait_until(t0 + 45);
        check("conf_blocked", int'(dut.r_state), 5);
        check("conf_up_db", int'(up_db), 0);
        check("conf_dn_db", int'(dn_db), 1);
        wait_until(t0 + 50);
        btn_dn = 1'b0;
        tick(15);
        check("conf_incr", incr_times.size(), 1);
        check("conf_decr", decr_times.size(), 0);
        rep_en = 1'b0;
        btn_dn = 1'b1;
        tick(12);
        check("conf_next_decr", decr_times.size(), 1);
        btn_dn = 1'b0;
        tick(12);
        clear_log();

        // Simultaneous press.
        btn_up = 1'b1;
        btn_dn = 1'b1;
        tick(12);
        check("sim_blocked", int'(dut.r_state), 5);
        check("sim_no_incr", incr_times.size(), 0);
        check("sim_no_decr", decr_times.size(), 0);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick(12);
        check("sim_idle", int'(dut.r_state), 0);
        btn_up = 1'b1;
        tick(12);
        check("sim_then_incr", incr_times.size(), 1);
        btn_up = 1'b0;
        tick(12);

        // Counter integration, fresh reset.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 12; i++) begin
            btn_up = 1'b1;
            tick(10);
            btn_up = 1'b0;
            tick(10);
        end
        check("cnt_sat9", digit, 9);
        check("cnt_incr_pulses", incr_times.size(), 12);
        for (int i = 0; i < 3; i++) begin
            btn_dn = 1'b1;
            tick(10);
            btn_dn = 1'b0;
            tick(10);
        end
        check("cnt_down6", digit, 6);
        check("cnt_decr_pulses", decr_times.size(), 3);

        check("never_both_high", both_hi, 0);
        check("never_wide_pulse", wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
